// File: rtl/biquad8_coeff_loader.sv
// Coefficient writer for biquad8_pole_iir: register-bus shadow bank, snapshot on commit,
// serial shift into the DSP B-cascade (coeff_wr_o) followed by a single coeff_update_o load pulse.
module biquad8_coeff_loader #(
  parameter int NCOEFF     = 4,
  parameter int ADDR_BITS  = 2,
  parameter int COEFF_BITS = 18,
  parameter int WR_GAP     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr,
  input  logic [ADDR_BITS-1:0]  cfg_addr,
  input  logic [COEFF_BITS-1:0] cfg_dat,
  output logic [COEFF_BITS-1:0] cfg_rdat,
  input  logic                  cfg_commit,
  output logic                  busy,
  output logic                  done,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);

  localparam int CNT_BITS = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]            state;
  logic [CNT_BITS-1:0]   cnt;
  logic [3:0]            gap_cnt;
  logic                  pending;
  logic                  start;
  logic [COEFF_BITS-1:0] shadow      [NCOEFF];
  logic [COEFF_BITS-1:0] shadow_next [NCOEFF];
  logic [COEFF_BITS-1:0] snapshot    [NCOEFF];
  logic [COEFF_BITS-1:0] rd_val;
  logic [COEFF_BITS-1:0] shift_val;

  // shadow_next folds in a same-cycle cfg_wr so a commit snapshot sees it (write-through).
  // Address decode by comparison means out-of-range addresses simply match nothing.
  always_comb begin
    rd_val    = '0;
    shift_val = '0;
    for (int k = 0; k < NCOEFF; k++) begin
      shadow_next[k] = shadow[k];
      if (cfg_wr && cfg_addr == ADDR_BITS'(k)) shadow_next[k] = cfg_dat;
      if (cfg_addr == ADDR_BITS'(k)) rd_val = shadow[k];
      if (cnt == CNT_BITS'(k)) shift_val = snapshot[k];
    end
  end

  // A new load begins from IDLE, or straight out of UPDATE when a commit is queued.
  assign start = ((state == S_IDLE) || (state == S_UPDATE)) && (cfg_commit || pending);

  // NOTE: the shadow bank is a register array with a real reset because readback and
  // an early commit must see zeros; it is not meant to map onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rdat <= '0;
      for (int k = 0; k < NCOEFF; k++) shadow[k] <= '0;
    end else begin
      cfg_rdat <= rd_val;
      for (int k = 0; k < NCOEFF; k++) shadow[k] <= shadow_next[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      gap_cnt        <= '0;
      pending        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      coeff_dat_o    <= '0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      for (int k = 0; k < NCOEFF; k++) snapshot[k] <= '0;
    end else begin
      coeff_wr_o     <= 1'b0;
      coeff_dat_o    <= '0;
      coeff_update_o <= 1'b0;
      done           <= 1'b0;
      busy           <= (state != S_IDLE);

      if (cfg_commit && (state == S_SHIFT || state == S_GAP)) pending <= 1'b1;

      case (state)
        S_SHIFT: begin
          coeff_wr_o  <= 1'b1;
          coeff_dat_o <= shift_val;
          if (cnt == '0) begin
            state <= S_UPDATE;
          end else begin
            cnt <= cnt - 1'b1;
            if (WR_GAP > 0) begin
              state   <= S_GAP;
              gap_cnt <= 4'(WR_GAP - 1);
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == '0) state   <= S_SHIFT;
          else               gap_cnt <= gap_cnt - 1'b1;
        end
        S_UPDATE: begin
          coeff_update_o <= 1'b1;
          done           <= 1'b1;
          state          <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (start) begin
        for (int k = 0; k < NCOEFF; k++) snapshot[k] <= shadow_next[k];
        cnt     <= CNT_BITS'(NCOEFF - 1);
        pending <= 1'b0;
        state   <= S_SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Scoreboard bench for biquad8_coeff_loader: two instances (no gap and WR_GAP=2) share stimulus;
// a load-schedule model pushes expected chain events, a negedge monitor pops and compares.
module tb_biquad8_coeff_loader;

  localparam int NC   = 4;
  localparam int AB   = 3;
  localparam int CB   = 18;
  localparam int GAP1 = 2;
  localparam int MAXC = 4096;

  typedef struct {
    int            cyc;
    bit            upd;
    logic [CB-1:0] dat;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_wr, cfg_commit;
  logic [AB-1:0] cfg_addr;
  logic [CB-1:0] cfg_dat;

  logic [CB-1:0] rdat0, rdat1, dat0, dat1;
  logic          busy0, busy1, done0, done1, wr0, wr1, upd0, upd1;

  biquad8_coeff_loader #(.NCOEFF(NC), .ADDR_BITS(AB), .COEFF_BITS(CB), .WR_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_dat(cfg_dat),
    .cfg_rdat(rdat0), .cfg_commit(cfg_commit), .busy(busy0), .done(done0),
    .coeff_dat_o(dat0), .coeff_wr_o(wr0), .coeff_update_o(upd0));

  biquad8_coeff_loader #(.NCOEFF(NC), .ADDR_BITS(AB), .COEFF_BITS(CB), .WR_GAP(GAP1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_dat(cfg_dat),
    .cfg_rdat(rdat1), .cfg_commit(cfg_commit), .busy(busy1), .done(done1),
    .coeff_dat_o(dat1), .coeff_wr_o(wr1), .coeff_update_o(upd1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: shadow contents, per-instance pending flag and end of current load.
  logic [CB-1:0] shadow_m [NC];
  bit            pend     [2];
  int            upd_edge [2];
  bit            busy_exp [2][MAXC];
  logic [CB-1:0] rdat_exp [MAXC];
  ev_t           q0[$];
  ev_t           q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic ev_t qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int i);
    if (i == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  task automatic qpush(input int i, input ev_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One load started at edge s: writes go out tail-first, spaced by the gap, then one update.
  task automatic model_edge(input int i, input int s, input logic commit);
    int  gap, len;
    ev_t e;
    gap = (i == 0) ? 0 : GAP1;
    len = NC + (NC - 1) * gap + 1;
    if ((commit || pend[i]) && s >= upd_edge[i]) begin
      pend[i]     = 1'b0;
      upd_edge[i] = s + len;
      for (int k = 0; k < NC; k++) begin
        e.cyc = s + 1 + k * (gap + 1);
        e.upd = 1'b0;
        e.dat = shadow_m[NC - 1 - k];
        qpush(i, e);
      end
      e.cyc = s + len;
      e.upd = 1'b1;
      e.dat = '0;
      qpush(i, e);
      for (int t = s + 1; t <= s + len && t < MAXC; t++) busy_exp[i][t] = 1'b1;
    end else if (commit) begin
      pend[i] = 1'b1;
    end
  endtask

  // Drive inputs for the next rising edge, advance the model, then move 1 ns past that edge.
  task automatic step(input logic w, input logic [AB-1:0] a, input logic [CB-1:0] d,
                      input logic c);
    int e;
    cfg_wr     = w;
    cfg_addr   = a;
    cfg_dat    = d;
    cfg_commit = c;
    e = cyc + 1;
    if (e < MAXC) rdat_exp[e] = (int'(a) < NC) ? shadow_m[a] : '0;
    if (w && int'(a) < NC) shadow_m[a] = d;
    model_edge(0, e, c);
    model_edge(1, e, c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, AB'($urandom_range(0, 7)), '0, 1'b0);
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      pend[i]     = 1'b0;
      upd_edge[i] = -1;
      for (int t = cyc; t < MAXC; t++) busy_exp[i][t] = 1'b0;
    end
    for (int t = cyc; t < MAXC; t++) rdat_exp[t] = '0;
    for (int k = 0; k < NC; k++) shadow_m[k] = '0;
  endtask

  // Called 1 ns after an edge; reset lands mid-cycle, well before the sampling edge.
  task automatic do_reset();
    #2;
    rst_n      = 1'b0;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    model_clear();
    #1;
    check("async reset coeff_wr_o[dut0]", {31'd0, wr0}, 32'd0);
    check("async reset coeff_wr_o[dut1]", {31'd0, wr1}, 32'd0);
    check("async reset coeff_dat_o[dut0]", {14'd0, dat0}, 32'd0);
    check("async reset busy[dut1]", {31'd0, busy1}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic mon(input int i, input logic wr, input logic upd, input logic dn,
                     input logic bsy, input logic [CB-1:0] dat, input logic [CB-1:0] rd);
    int            c;
    ev_t           e;
    logic          ew, eu;
    logic [CB-1:0] ed;
    c  = cyc;
    ew = 1'b0;
    eu = 1'b0;
    ed = '0;
    while (qsize(i) > 0) begin
      e = qfront(i);
      if (e.cyc >= c) break;
      qpop(i);
      check($sformatf("missed event dut%0d cyc %0d", i, e.cyc), 32'd0, 32'd1);
    end
    if (qsize(i) > 0) begin
      e = qfront(i);
      if (e.cyc == c) begin
        qpop(i);
        eu = e.upd;
        ew = !e.upd;
        ed = e.upd ? '0 : e.dat;
      end
    end
    check($sformatf("coeff_wr_o dut%0d cyc %0d", i, c), {31'd0, wr}, {31'd0, ew});
    check($sformatf("coeff_dat_o dut%0d cyc %0d", i, c), {14'd0, dat}, {14'd0, ed});
    check($sformatf("coeff_update_o dut%0d cyc %0d", i, c), {31'd0, upd}, {31'd0, eu});
    check($sformatf("done dut%0d cyc %0d", i, c), {31'd0, dn}, {31'd0, eu});
    check($sformatf("busy dut%0d cyc %0d", i, c), {31'd0, bsy},
          {31'd0, (c < MAXC) ? busy_exp[i][c] : 1'b0});
    check($sformatf("cfg_rdat dut%0d cyc %0d", i, c), {14'd0, rd},
          {14'd0, (c < MAXC) ? rdat_exp[c] : 18'd0});
  endtask

  always @(negedge clk) begin
    mon(0, wr0, upd0, done0, busy0, dat0, rdat0);
    mon(1, wr1, upd1, done1, busy1, dat1, rdat1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    cfg_addr   = '0;
    cfg_dat    = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic load: shadow 0..3 then one commit.
    step(1'b1, 3'd0, 18'h00011, 1'b0);
    step(1'b1, 3'd1, 18'h00022, 1'b0);
    step(1'b1, 3'd2, 18'h00033, 1'b0);
    step(1'b1, 3'd3, 18'h00044, 1'b0);
    step(1'b0, 3'd0, '0, 1'b1);
    idle(20);

    // Commit while loading, with shadow[2] rewritten mid-load: two back-to-back loads.
    step(1'b0, 3'd2, '0, 1'b1);
    idle(2);
    step(1'b1, 3'd2, 18'h3FFFF, 1'b1);
    idle(40);

    // Write-through of a same-cycle write, then an out-of-range write and readback.
    step(1'b1, 3'd1, 18'h2AAAA, 1'b1);
    idle(20);
    step(1'b1, 3'd5, 18'h12345, 1'b0);
    step(1'b0, 3'd5, '0, 1'b0);
    step(1'b0, 3'd7, '0, 1'b0);
    for (int k = 0; k < NC; k++) step(1'b0, AB'(k), '0, 1'b0);

    // Reset during the third write pulse of dut0, then a fresh full load.
    step(1'b0, 3'd0, '0, 1'b1);
    idle(3);
    do_reset();
    idle(2);
    for (int k = 0; k < NC; k++) step(1'b1, AB'(k), CB'($urandom), 1'b0);
    step(1'b0, 3'd0, '0, 1'b1);
    idle(20);

    // Random traffic: writes anywhere in the address space, sporadic commits.
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 3) == 0), AB'($urandom_range(0, 7)), CB'($urandom),
           ($urandom_range(0, 24) == 0));
    end
    idle(40);

    check("dut0 expected events left", q0.size(), 32'd0);
    check("dut1 expected events left", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
